// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: access-size codes and FSM state encoding.
package mem_access_ctrl_pkg;

   localparam logic [2:0] SIZE_W  = 3'd0;
   localparam logic [2:0] SIZE_H  = 3'd1;
   localparam logic [2:0] SIZE_B  = 3'd2;
   localparam logic [2:0] SIZE_HU = 3'd3;
   localparam logic [2:0] SIZE_BU = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_align_check.sv
// Combinational misalignment decode: halfwords need an even address, words a 4-byte boundary,
// and unknown size codes are always rejected. Used only when MEM_ALIGN_CHECK_EN is defined.
module align_check
   import mem_access_ctrl_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic       misaligned
);

   always_comb begin
      misaligned = 1'b0;
      case (size)
         SIZE_W:           misaligned = (addr_lo != 2'b00);
         SIZE_H, SIZE_HU:  misaligned = addr_lo[0];
         SIZE_B, SIZE_BU:  misaligned = 1'b0;
         default:          misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer: IDLE -> ACCESS -> WAIT(WAIT_CYCLES) -> DONE, response 2+WAIT_CYCLES after accept.
// Optional macro MEM_ALIGN_CHECK_EN short-circuits misaligned requests straight to DONE with err_valid.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        dm_wr,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_din,
   output logic [2:0]  dm_size,
   input  logic [31:0] dm_dout,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [31:0] resp_pc,
   output logic        err_valid
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pc_q, pc_d;
   logic        dm_wr_q, dm_wr_d;
   logic        resp_valid_q, resp_valid_d;
   logic        err_valid_q, err_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rpc_q, rpc_d;
   logic        misaligned;
   logic        finish;
   logic        in_access;

`ifdef MEM_ALIGN_CHECK_EN
   align_check u_align_check (
      .size       (req_size),
      .addr_lo    (req_addr[1:0]),
      .misaligned (misaligned)
   );
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pc_d         = pc_q;
      dm_wr_d      = 1'b0;
      resp_valid_d = 1'b0;
      err_valid_d  = 1'b0;
      rdata_d      = rdata_q;
      rpc_d        = rpc_q;
      finish       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               pc_d    = req_pc;
               if (misaligned) begin
                  state_d      = ST_DONE;
                  resp_valid_d = 1'b1;
                  err_valid_d  = 1'b1;
                  rdata_d      = '0;
                  rpc_d        = req_pc;
               end else begin
                  state_d = ST_ACCESS;
                  dm_wr_d = req_we;
               end
            end
         end
         ST_ACCESS: begin
            if (WAIT_CYCLES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
            end else begin
               finish = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               finish = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // memory read data is sampled on the edge that leaves the last settle cycle
      if (finish) begin
         state_d      = ST_DONE;
         resp_valid_d = 1'b1;
         rdata_d      = we_q ? 32'd0 : dm_dout;
         rpc_d        = pc_q;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         pc_q         <= '0;
         dm_wr_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         err_valid_q  <= 1'b0;
         rdata_q      <= '0;
         rpc_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pc_q         <= pc_d;
         dm_wr_q      <= dm_wr_d;
         resp_valid_q <= resp_valid_d;
         err_valid_q  <= err_valid_d;
         rdata_q      <= rdata_d;
         rpc_q        <= rpc_d;
      end
   end

   assign in_access  = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
   assign req_ready  = (state_q == ST_IDLE);
   assign dm_wr      = dm_wr_q;
   assign dm_addr    = in_access ? addr_q  : 32'd0;
   assign dm_din     = in_access ? wdata_q : 32'd0;
   assign dm_size    = in_access ? size_q  : 3'd0;
   assign resp_valid = resp_valid_q;
   assign err_valid  = err_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_pc    = rpc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_CYCLES 1, 3, 0) share one stimulus stream and are
// checked every cycle against a transaction-schedule model, plus directed literal expectations.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        Reset;
   logic        req_valid, req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr, req_wdata, req_pc, dm_dout;

   logic        o_ready[3], o_wr[3], o_rv[3], o_err[3];
   logic [31:0] o_addr[3], o_din[3], o_rdata[3], o_pc[3];
   logic [2:0]  o_size[3];

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   int t0 = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(o_ready[0]), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .dm_wr(o_wr[0]), .dm_addr(o_addr[0]), .dm_din(o_din[0]), .dm_size(o_size[0]), .dm_dout(dm_dout),
      .resp_valid(o_rv[0]), .resp_rdata(o_rdata[0]), .resp_pc(o_pc[0]), .err_valid(o_err[0]));

   mem_access_ctrl #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(o_ready[1]), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .dm_wr(o_wr[1]), .dm_addr(o_addr[1]), .dm_din(o_din[1]), .dm_size(o_size[1]), .dm_dout(dm_dout),
      .resp_valid(o_rv[1]), .resp_rdata(o_rdata[1]), .resp_pc(o_pc[1]), .err_valid(o_err[1]));

   mem_access_ctrl #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(o_ready[2]), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .dm_wr(o_wr[2]), .dm_addr(o_addr[2]), .dm_din(o_din[2]), .dm_size(o_size[2]), .dm_dout(dm_dout),
      .resp_valid(o_rv[2]), .resp_rdata(o_rdata[2]), .resp_pc(o_pc[2]), .err_valid(o_err[2]));

   function automatic int wv(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
   endfunction

   function automatic bit mis(input logic [2:0] s, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      return (s == 3'd0 && a[1:0] != 2'b00) || ((s == 3'd1 || s == 3'd3) && a[0]) || (s > 3'd4);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // Model: each accepted request occupies cycles acc+1..done; data is visible in acc+1..acc+1+W.
   bit          m_act[3], m_err[3], m_we[3];
   int          m_acc[3], m_done[3];
   logic [2:0]  m_size[3];
   logic [31:0] m_addr[3], m_wdata[3], m_pc[3], m_rdata[3], m_rpc[3];

   always @(posedge clk) begin
      int e;
      bit busy;
      e = cyc;
      for (int i = 0; i < 3; i++) begin
         if (Reset) begin
            m_act[i] = 0; m_rdata[i] = '0; m_rpc[i] = '0;
         end else begin
            busy = m_act[i] && e >= m_acc[i] + 1 && e <= m_done[i];
            if (req_valid && !busy) begin
               m_act[i] = 1; m_acc[i] = e; m_err[i] = mis(req_size, req_addr);
               m_we[i] = req_we; m_size[i] = req_size; m_addr[i] = req_addr;
               m_wdata[i] = req_wdata; m_pc[i] = req_pc;
               m_done[i] = e + (m_err[i] ? 1 : 2 + wv(i));
            end
            if (m_act[i] && e == m_done[i] - 1) begin
               m_rdata[i] = (m_we[i] || m_err[i]) ? 32'd0 : dm_dout;
               m_rpc[i] = m_pc[i];
            end
         end
      end
      cyc = e + 1;
   end

   always @(negedge clk) begin
      bit busy, inacc, rv;
      for (int i = 0; i < 3; i++) begin
         busy  = !Reset && m_act[i] && cyc >= m_acc[i] + 1 && cyc <= m_done[i];
         inacc = busy && !m_err[i] && cyc <= m_acc[i] + 1 + wv(i);
         rv    = busy && cyc == m_done[i];
         chk($sformatf("i%0d req_ready", i), 32'(o_ready[i]), 32'(!busy));
         chk($sformatf("i%0d dm_wr", i), 32'(o_wr[i]), 32'(inacc && m_we[i] && cyc == m_acc[i] + 1));
         chk($sformatf("i%0d dm_addr", i), o_addr[i], inacc ? m_addr[i] : 32'd0);
         chk($sformatf("i%0d dm_din", i), o_din[i], inacc ? m_wdata[i] : 32'd0);
         chk($sformatf("i%0d dm_size", i), 32'(o_size[i]), inacc ? 32'(m_size[i]) : 32'd0);
         chk($sformatf("i%0d resp_valid", i), 32'(o_rv[i]), 32'(rv));
         chk($sformatf("i%0d err_valid", i), 32'(o_err[i]), 32'(rv && m_err[i]));
         chk($sformatf("i%0d resp_rdata", i), o_rdata[i], Reset ? 32'd0 : m_rdata[i]);
         chk($sformatf("i%0d resp_pc", i), o_pc[i], Reset ? 32'd0 : m_rpc[i]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at(input int n);
      while (cyc < t0 + n) tick();
      @(negedge clk);
   endtask

   task automatic issue(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc);
      req_we = we; req_size = sz; req_addr = a; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
      tick();
      t0 = cyc - 1;
      req_valid = 1'b0;
      req_we = ~we; req_size = 3'd2; req_addr = 32'hA5A5_A5A5; req_wdata = 32'h5A5A_5A5A; req_pc = 32'hFFFF_0000;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  sz;
      logic [31:0] a, wd, pc, dout;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
      req_addr = '0; req_wdata = '0; req_pc = '0; dm_dout = '0;
      idle(2);
      Reset = 1'b0;
      @(negedge clk);
      chk("post-reset ready", 32'(o_ready[0]), 32'd1);
      chk("post-reset resp_valid", 32'(o_rv[0]), 32'd0);
      idle(1);

      // store word
      issue(1'b1, 3'd0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0400);
      at(1);
      chk("sw dm_wr c1", 32'(o_wr[0]), 32'd1);
      chk("sw dm_addr c1", o_addr[0], 32'h10);
      chk("sw dm_din c1", o_din[0], 32'hDEAD_BEEF);
      chk("sw dm_size c1", 32'(o_size[0]), 32'd0);
      at(2);
      chk("sw dm_wr c2", 32'(o_wr[0]), 32'd0);
      at(3);
      chk("sw resp_valid c3", 32'(o_rv[0]), 32'd1);
      chk("sw resp_rdata c3", o_rdata[0], 32'd0);
      idle(6);

      // load byte
      dm_dout = 32'hFFFF_FF80;
      issue(1'b0, 3'd2, 32'h13, 32'h0, 32'h0000_0100);
      at(1);
      chk("lb dm_wr c1", 32'(o_wr[0]), 32'd0);
      at(3);
      chk("lb resp_valid c3", 32'(o_rv[0]), 32'd1);
      chk("lb resp_rdata c3", o_rdata[0], 32'hFFFF_FF80);
      chk("lb resp_pc c3", o_pc[0], 32'h0000_0100);
      idle(6);

      // back-to-back with req_valid held high
      dm_dout = 32'h1234_5678;
      req_we = 1'b0; req_size = 3'd0; req_addr = 32'h40; req_wdata = '0; req_pc = 32'h200; req_valid = 1'b1;
      tick();
      t0 = cyc - 1;
      req_addr = 32'h44; req_pc = 32'h204;
      at(1); chk("b2b ready c1", 32'(o_ready[0]), 32'd0);
      at(2); chk("b2b ready c2", 32'(o_ready[0]), 32'd0);
      at(3); chk("b2b ready c3", 32'(o_ready[0]), 32'd0);
      at(4); chk("b2b ready c4", 32'(o_ready[0]), 32'd1);
      at(5); chk("b2b second dm_addr c5", o_addr[0], 32'h44);
      at(6);
      req_valid = 1'b0;
      idle(8);

      // misaligned lw
      issue(1'b0, 3'd0, 32'h02, 32'h0, 32'h300);
`ifdef MEM_ALIGN_CHECK_EN
      at(1);
      chk("mis resp_valid c1", 32'(o_rv[0]), 32'd1);
      chk("mis err_valid c1", 32'(o_err[0]), 32'd1);
      chk("mis dm_wr c1", 32'(o_wr[0]), 32'd0);
      chk("mis dm_addr c1", o_addr[0], 32'd0);
`else
      at(1);
      chk("mis dm_addr c1", o_addr[0], 32'h02);
      at(3);
      chk("mis resp_valid c3", 32'(o_rv[0]), 32'd1);
      chk("mis err_valid c3", 32'(o_err[0]), 32'd0);
`endif
      idle(6);

      // reset during the second WAIT cycle of the WAIT_CYCLES=3 instance
      issue(1'b1, 3'd0, 32'h80, 32'hCAFE_F00D, 32'h500);
      at(2);
      tick();
      Reset = 1'b1;
      @(negedge clk);
      chk("rst dm_wr", 32'(o_wr[1]), 32'd0);
      chk("rst dm_addr", o_addr[1], 32'd0);
      chk("rst dm_din", o_din[1], 32'd0);
      chk("rst resp_valid", 32'(o_rv[1]), 32'd0);
      tick();
      Reset = 1'b0;
      @(negedge clk);
      chk("rst ready after release", 32'(o_ready[1]), 32'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (o_rv[1] || o_wr[1]) seen = 1'b1;
      end
      chk("rst no later resp/wr", 32'(seen), 32'd0);
      idle(2);

      // zero wait cycles
      dm_dout = 32'h0000_BEEF;
      issue(1'b0, 3'd0, 32'h20, 32'h0, 32'h600);
      at(1);
      chk("w0 dm_addr c1", o_addr[2], 32'h20);
      at(2);
      chk("w0 resp_valid c2", 32'(o_rv[2]), 32'd1);
      chk("w0 resp_rdata c2", o_rdata[2], 32'h0000_BEEF);
      chk("w0 dm_addr c2", o_addr[2], 32'd0);
      idle(6);

      // assorted sizes and alignments, checked by the model
      tbl[0] = '{1'b0, 3'd3, 32'h22, 32'h0, 32'h700, 32'h0000_8001};
      tbl[1] = '{1'b1, 3'd1, 32'h31, 32'h0000_ABCD, 32'h704, 32'h0};
      tbl[2] = '{1'b0, 3'd4, 32'h37, 32'h0, 32'h708, 32'h0000_00FE};
      tbl[3] = '{1'b1, 3'd5, 32'h40, 32'h1111_2222, 32'h70C, 32'h0};
      tbl[4] = '{1'b0, 3'd1, 32'h51, 32'h0, 32'h710, 32'hFFFF_9000};
      tbl[5] = '{1'b1, 3'd2, 32'h63, 32'h0000_0077, 32'h714, 32'h0};
      foreach (tbl[k]) begin
         dm_dout = tbl[k].dout;
         issue(tbl[k].we, tbl[k].sz, tbl[k].a, tbl[k].wd, tbl[k].pc);
         idle(7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high; ports named clk and Reset.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of read-settle cycles after issue (legal range 0..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  pipeline request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  3  access-size code from the shared package.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_pc  input  32  PC of the issuing instruction.
REQ-012 dm_wr  output  1  data-memory write strobe.
REQ-013 dm_addr  output  32  data-memory byte address.
REQ-014 dm_din  output  32  data-memory write data.
REQ-015 dm_size  output  3  size code to the data memory.
REQ-016 dm_dout  input  32  data-memory read data (already extended by memory).
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 resp_rdata  output  32  load result (0 for stores).
REQ-019 resp_pc  output  32  PC of the completed request.
REQ-020 err_valid  output  1  alignment/size error, qualified by resp_valid.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-022 Transitions:
- IDLE -> ACCESS on req_valid && req_ready.
- ACCESS -> WAIT if WAIT_CYCLES > 0, else ACCESS -> DONE.
- WAIT -> DONE when the 4-bit wait counter reaches 0.
- DONE -> IDLE unconditionally.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on the clock edge where req_valid && req_ready.
REQ-024 On accept, the block SHALL register we, size, addr, wdata and pc; later changes on the req_* inputs SHALL have no effect until the next IDLE.
REQ-025 dm_addr, dm_size and dm_din SHALL be driven from the registered request and held stable through ACCESS and WAIT; in IDLE and DONE they SHALL be 0.
REQ-026 dm_wr SHALL be a registered output, high for exactly the single ACCESS cycle of a store and low at all other times.
REQ-027 The wait counter SHALL load WAIT_CYCLES-1 on entering WAIT and decrement each cycle.
REQ-028 Load data: dm_dout SHALL be captured into resp_rdata on the edge leaving the last ACCESS/WAIT cycle.
REQ-029 Store data: resp_rdata SHALL be 0.
REQ-030 resp_valid SHALL be high for exactly the DONE cycle; resp_rdata and resp_pc SHALL hold their values until the next DONE.
REQ-031 Latency: with the accept edge at cycle 0, resp_valid SHALL be high in cycle 2+WAIT_CYCLES, for loads and stores alike.
REQ-032 Misalignment is defined as:
- H or HU with addr[0] = 1;
- W with addr[1:0] != 0;
- any size code other than W, H, B, HU, BU.

Reset
REQ-033 Reset SHALL asynchronously force: state IDLE, dm_wr 0, resp_valid 0, err_valid 0, counter 0, and all registered data 0.
REQ-034 Reset asserted mid-operation SHALL abort the access without any further dm_wr pulse.
REQ-035 req_ready SHALL be 1 in the first cycle after Reset is released.

Configuration
REQ-036 Macro MEM_ALIGN_CHECK_EN, when defined:
- a misaligned request SHALL go IDLE -> DONE directly, with err_valid = 1 and resp_valid = 1;
- no dm_wr pulse, and dm_addr stays 0;
- latency is 1 cycle.
REQ-037 Macro MEM_ALIGN_CHECK_EN, when undefined:
- err_valid SHALL be tied 0;
- every request follows the normal path with the raw address passed to dm_addr.

Structure
REQ-038 A shared package SHALL hold the size codes (W=0, H=1, B=2, HU=3, BU=4) and the 2-bit state encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3).
REQ-039 Misalignment decode SHALL live in one combinational sub-module named align_check, instantiated only when MEM_ALIGN_CHECK_EN is defined.

Verification
REQ-040 Store word, WAIT_CYCLES=1: addr 0x00000010, wdata 0xDEADBEEF -> dm_wr high in cycle 1 only, dm_addr=0x10, dm_din=0xDEADBEEF, dm_size=0; resp_valid in cycle 3 with resp_rdata=0.
REQ-041 Load byte, WAIT_CYCLES=1: addr 0x13, size B, dm_dout=0xFFFFFF80 -> dm_wr never high; resp_valid in cycle 3 with resp_rdata=0xFFFFFF80 and resp_pc equal to req_pc.
REQ-042 Back-to-back: req_valid held high with two requests -> req_ready low in cycles 1..3; second request accepted at the cycle-4 edge.
REQ-043 Misaligned lw at addr 0x02:
- macro defined -> resp_valid=1 and err_valid=1 in cycle 1, no dm_wr;
- macro undefined -> normal access with dm_addr=0x02 and resp_valid in cycle 3.
REQ-044 Reset mid-store: WAIT_CYCLES=3, Reset pulsed in the second WAIT cycle -> all outputs 0 immediately, no resp_valid; req_ready=1 in the first cycle after release.
REQ-045 WAIT_CYCLES=0: load at addr 0x20 -> WAIT state skipped, resp_valid in cycle 2.
